// File: rtl/temp_sense_pkg.sv
// Shared types and default sizing for the VCO temperature-sensor conversion sequencer.
package temp_sense_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int GATE_W_DEF  = 16;
  localparam int DIV_W_DEF   = 8;
  localparam int RST_CYC_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_GATE,
    ST_SETTLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sense_shift_clkgen.sv
// Shift-clock divider for reading the sensor shift register: low-first square wave,
// a strobe on each rising edge, and a done strobe on the falling edge after CNT_W rises.
module sense_shift_clkgen
  import temp_sense_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             shift_clk,
  output logic             rise_stb,
  output logic             done
);

  localparam int EW = $clog2(CNT_W + 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic             shift_clk_q, shift_clk_d;
  logic             tick;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    shift_clk_d = shift_clk_q;
    tick        = en && (div_cnt_q == div);
    if (!en) begin
      div_cnt_d   = '0;
      edge_cnt_d  = '0;
      shift_clk_d = 1'b0;
    end else if (tick) begin
      div_cnt_d   = '0;
      shift_clk_d = ~shift_clk_q;
      if (!shift_clk_q) edge_cnt_d = edge_cnt_q + 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  assign rise_stb  = tick && !shift_clk_q;
  assign done      = tick && shift_clk_q && (edge_cnt_q == EW'(CNT_W));
  assign shift_clk = shift_clk_q;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      shift_clk_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      shift_clk_q <= shift_clk_d;
    end
  end

endmodule

// File: rtl/temp_sense_sequencer.sv
// Runs one sensor conversion: counter reset, timed count gate, settle, serial readout,
// then publishes the result with a sticky interrupt and overrun flag.
module temp_sense_sequencer
  import temp_sense_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GATE_W  = GATE_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RST_CYC = RST_CYC_DEF
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cont_en_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  input  logic [DIV_W-1:0]  shift_div_i,
  input  logic              irq_clr_i,
  input  logic              sr_in,
  output logic              sns_rst_o,
  output logic              gate_o,
  output logic              shift_clk_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  result_o,
  output logic              result_valid_o,
  output logic              irq_o,
  output logic              ovr_o
);

  state_e            state_q, state_d;
  logic [GATE_W-1:0] cnt_q, cnt_d;
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              irq_q, irq_d, ovr_q, ovr_d;
  logic              sns_rst_q, gate_q, busy_q, valid_q;
  logic              load_cfg, rise_stb, sclk_done;

  sense_shift_clkgen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_clkgen (
    .clk       (wb_clk_i),
    .rst_n     (rst_n),
    .en        (state_q == ST_SHIFT),
    .div       (div_q),
    .shift_clk (shift_clk_o),
    .rise_stb  (rise_stb),
    .done      (sclk_done)
  );

  // Configuration is captured whenever a new conversion begins, including continuous re-arm.
  assign load_cfg = ((state_q == ST_IDLE) && (start_i || cont_en_i)) ||
                    ((state_q == ST_DONE) && cont_en_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gate_len_d = gate_len_q;
    div_d      = div_q;
    shift_d    = shift_q;
    result_d   = result_q;
    irq_d      = irq_q;
    ovr_d      = ovr_q;

    if (load_cfg) begin
      gate_len_d = (gate_cycles_i == '0) ? GATE_W'(1) : gate_cycles_i;
      div_d      = shift_div_i;
    end

    case (state_q)
      ST_IDLE: if (start_i || cont_en_i) begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
      ST_RST: if (cnt_q == GATE_W'(RST_CYC - 1)) begin
        state_d = ST_GATE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_GATE: if (cnt_q == gate_len_q - 1'b1) begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_SETTLE: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (rise_stb) shift_d = {shift_q[CNT_W-2:0], sr_in};
        if (sclk_done) begin
          state_d  = ST_DONE;
          result_d = shift_q;
        end
      end
      ST_DONE: begin
        state_d = cont_en_i ? ST_RST : ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear first so a completing conversion in the same cycle wins; ovr looks at the old irq.
    if (irq_clr_i) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (state_q == ST_DONE) begin
      irq_d = 1'b1;
      if (irq_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gate_len_q <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      result_q   <= '0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      sns_rst_q  <= 1'b0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_len_q <= gate_len_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      result_q   <= result_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
      sns_rst_q  <= (state_d == ST_RST);
      gate_q     <= (state_d == ST_GATE);
      busy_q     <= (state_d != ST_IDLE);
      valid_q    <= (state_d == ST_DONE);
    end
  end

  assign sns_rst_o      = sns_rst_q;
  assign gate_o         = gate_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign irq_o          = irq_q;
  assign ovr_o          = ovr_q;

endmodule

// File: tb/tb_temp_sense_sequencer.sv
// Self-checking bench: vector table of single-shot conversions plus hand-written
// continuous, busy-start and mid-shift reset sequences, with a result scoreboard.
module tb_temp_sense_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        cont_en_i = 1'b0;
  logic [15:0] gate_cycles_i = '0;
  logic [7:0]  shift_div_i = '0;
  logic        irq_clr_i = 1'b0;
  logic        sr_in = 1'b0;
  logic        sns_rst_o, gate_o, shift_clk_o, busy_o;
  logic [15:0] result_o;
  logic        result_valid_o, irq_o, ovr_o;

  temp_sense_sequencer dut (
    .wb_clk_i       (wb_clk_i),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .cont_en_i      (cont_en_i),
    .gate_cycles_i  (gate_cycles_i),
    .shift_div_i    (shift_div_i),
    .irq_clr_i      (irq_clr_i),
    .sr_in          (sr_in),
    .sns_rst_o      (sns_rst_o),
    .gate_o         (gate_o),
    .shift_clk_o    (shift_clk_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .irq_o          (irq_o),
    .ovr_o          (ovr_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Sensor shift-register model: presents the MSB after reset, advances on each shift clock rise.
  logic [15:0] sense_word = '0;
  int          bit_idx = 15;
  always @(posedge shift_clk_o or posedge sns_rst_o) begin
    if (sns_rst_o) begin
      bit_idx = 15;
      sr_in   = sense_word[15];
    end else begin
      if (bit_idx > 0) bit_idx--;
      sr_in = sense_word[bit_idx];
    end
  end

  // Cumulative activity monitor; tests take snapshots and compare differences.
  int   cyc = 0;
  int   gate_total = 0, rst_total = 0, rise_total = 0, hi_err_total = 0, valid_total = 0;
  int   hi_run = 0;
  int   exp_div = 0;
  logic prev_sclk = 1'b0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;
  always @(negedge wb_clk_i) begin
    if (gate_o) gate_total++;
    if (sns_rst_o) rst_total++;
    if (result_valid_o) valid_total++;
    if (shift_clk_o && !prev_sclk) rise_total++;
    if (shift_clk_o) hi_run++;
    else begin
      if (prev_sclk && hi_run != exp_div + 1) hi_err_total++;
      hi_run = 0;
    end
    prev_sclk = shift_clk_o;
  end

  task automatic wait_valid(input string name);
    bit found = 0;
    logic [15:0] exp;
    for (int i = 0; i < 4000; i++) begin
      if (result_valid_o) begin
        found = 1;
        break;
      end
      @(negedge wb_clk_i);
    end
    check({name, "_valid_seen"}, 32'(found), 32'd1);
    if (found) begin
      if (exp_q.size() == 0) check({name, "_unexpected_result"}, 32'(result_o), 32'hFFFF_FFFF);
      else begin
        exp = exp_q.pop_front();
        check({name, "_result"}, 32'(result_o), 32'(exp));
      end
    end
  endtask

  task automatic clear_irq(input string name);
    @(negedge wb_clk_i) irq_clr_i = 1'b1;
    @(negedge wb_clk_i) irq_clr_i = 1'b0;
    check({name, "_irq_cleared"}, 32'({irq_o, ovr_o}), 32'd0);
  endtask

  task automatic run_single(input string name, input logic [15:0] g, input logic [7:0] d,
                            input logic [15:0] data, input int exp_lat, input int exp_gate);
    int g0, r0, e0, h0, c0;
    @(negedge wb_clk_i);
    g0 = gate_total; r0 = rst_total; e0 = rise_total; h0 = hi_err_total;
    gate_cycles_i = g; shift_div_i = d; exp_div = int'(d);
    sense_word = data; exp_q.push_back(data);
    start_i = 1'b1; c0 = cyc;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    gate_cycles_i = 16'hFFFF; shift_div_i = 8'hFF;
    wait_valid(name);
    check({name, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
    check({name, "_sclk_low_at_done"}, 32'({shift_clk_o, gate_o, sns_rst_o}), 32'd0);
    @(negedge wb_clk_i);
    check({name, "_idle_after"}, 32'({busy_o, result_valid_o}), 32'd0);
    check({name, "_irq_set"}, 32'({irq_o, ovr_o}), 32'b10);
    check({name, "_gate_cycles"}, 32'(gate_total - g0), 32'(exp_gate));
    check({name, "_rst_cycles"}, 32'(rst_total - r0), 32'd4);
    check({name, "_rises"}, 32'(rise_total - e0), 32'd16);
    check({name, "_high_runs"}, 32'(hi_err_total - h0), 32'd0);
    clear_irq(name);
  endtask

  typedef struct {
    string       name;
    logic [15:0] gate;
    logic [7:0]  div;
    logic [15:0] data;
    int          lat;
    int          gate_len;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int v0, r0;
    vecs[0] = '{"g3_d0",  16'd3, 8'd0, 16'hA5C3, 41,  3};
    vecs[1] = '{"g0_d0",  16'd0, 8'd0, 16'hFFFF, 39,  1};
    vecs[2] = '{"g5_d1",  16'd5, 8'd1, 16'h1234, 75,  5};
    vecs[3] = '{"g1_d2",  16'd1, 8'd2, 16'h8001, 103, 1};

    repeat (3) @(negedge wb_clk_i);
    check("reset_outputs", 32'({sns_rst_o, gate_o, shift_clk_o, busy_o, result_valid_o, irq_o, ovr_o}), 32'd0);
    check("reset_result", 32'(result_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("idle_no_start", 32'(busy_o), 32'd0);

    foreach (vecs[i]) run_single(vecs[i].name, vecs[i].gate, vecs[i].div, vecs[i].data, vecs[i].lat, vecs[i].gate_len);

    // Continuous mode: two results without clearing, clear coincident with second DONE.
    @(negedge wb_clk_i);
    v0 = valid_total; r0 = rst_total;
    gate_cycles_i = 16'd2; shift_div_i = 8'd0; exp_div = 0;
    sense_word = 16'h5A5A; exp_q.push_back(16'h5A5A); exp_q.push_back(16'h5A5A);
    cont_en_i = 1'b1;
    @(negedge wb_clk_i);
    wait_valid("cont1");
    @(negedge wb_clk_i);
    cont_en_i = 1'b0;
    check("cont_rearmed", 32'({busy_o, sns_rst_o}), 32'b11);
    @(negedge wb_clk_i);
    check("cont_irq_after_first", 32'({irq_o, ovr_o}), 32'b10);
    wait_valid("cont2");
    irq_clr_i = 1'b1;
    @(negedge wb_clk_i);
    irq_clr_i = 1'b0;
    check("cont_set_beats_clear", 32'({irq_o, ovr_o}), 32'b11);
    check("cont_stops_after_drop", 32'(busy_o), 32'd0);
    repeat (60) @(negedge wb_clk_i);
    check("cont_result_count", 32'(valid_total - v0), 32'd2);
    check("cont_rst_cycles", 32'(rst_total - r0), 32'd8);
    clear_irq("cont");

    // start_i pulsed during GATE is ignored.
    @(negedge wb_clk_i);
    v0 = valid_total;
    gate_cycles_i = 16'd6; shift_div_i = 8'd0;
    sense_word = 16'h0F0F; exp_q.push_back(16'h0F0F);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 50 && !gate_o; i++) @(negedge wb_clk_i);
    check("busy_start_in_gate", 32'(gate_o), 32'd1);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    wait_valid("busy_start");
    repeat (80) @(negedge wb_clk_i);
    check("busy_start_one_result", 32'(valid_total - v0), 32'd1);
    check("busy_start_idle", 32'(busy_o), 32'd0);

    // Asynchronous reset in the middle of SHIFT aborts and clears everything.
    @(negedge wb_clk_i);
    gate_cycles_i = 16'd1; shift_div_i = 8'd1; exp_div = 1;
    sense_word = 16'hC3C3; exp_q.push_back(16'hC3C3);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 50 && !shift_clk_o; i++) @(negedge wb_clk_i);
    check("abort_in_shift", 32'(shift_clk_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({sns_rst_o, gate_o, shift_clk_o, busy_o, result_valid_o, irq_o, ovr_o}), 32'd0);
    check("abort_result", 32'(result_o), 32'd0);
    exp_q.delete();
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    run_single("after_abort", 16'd2, 8'd1, 16'h3C96, 72, 2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
